// File: rtl/icache_ctrl.sv
// -----------------------------------------------------------------------------
// icache_ctrl: direct-mapped instruction cache controller.
//
// Holds 2^INDEX_BITS lines of 128 bits. Hits are returned one cycle after
// the request. Misses issue a single-cycle refill request to memory, wait for
// the line, write it into the cache and then return it. An Abort (redirect)
// kills the response but never the refill. A refill that takes MEM_TIMEOUT
// cycles raises a sticky Mem_err and is abandoned.
//
// Optional build macro:
//   ICACHE_PERF_CNT_EN  - enables the Hit_count / Miss_count counters; when
//                         undefined both outputs are tied to zero.
//
// Parameters:
//   INDEX_BITS   - line index width (2^INDEX_BITS lines)
//   MEM_TIMEOUT  - WAIT cycles tolerated before flagging Mem_err
//
// Ports:
//   clk            - clock, rising edge
//   reset          - asynchronous active-low reset
//   Pc_in          - fetch address
//   Rd_en          - fetch request (sampled only in IDLE)
//   Abort          - redirect, kills the in-flight response
//   Dout           - fetched line, word 0 in [127:96]; holds when not valid
//   Dout_valid     - one-cycle response strobe
//   Busy           - controller not in IDLE
//   Mem_addr       - line-aligned refill address
//   Mem_rd_en      - one-cycle refill request
//   Mem_data       - refill line
//   Mem_data_valid - refill line valid (honoured only in WAIT)
//   Mem_err        - sticky refill timeout flag
//   Hit_count      - accepted hit counter
//   Miss_count     - accepted miss counter
// -----------------------------------------------------------------------------
module icache_ctrl #(
   parameter int unsigned INDEX_BITS  = 4,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   Pc_in,
   input  logic          Rd_en,
   input  logic          Abort,
   output logic [127:0]  Dout,
   output logic          Dout_valid,
   output logic          Busy,
   output logic [31:0]   Mem_addr,
   output logic          Mem_rd_en,
   input  logic [127:0]  Mem_data,
   input  logic          Mem_data_valid,
   output logic          Mem_err,
   output logic [31:0]   Hit_count,
   output logic [31:0]   Miss_count
);

   localparam int unsigned NUM_LINES = 1 << INDEX_BITS;
   localparam int unsigned TAG_W     = 28 - INDEX_BITS;

   typedef enum logic [1:0] {
      StIdle,
      StMiss,
      StWait,
      StResp
   } state_e;

   state_e                 state_q, state_d;
   logic [NUM_LINES-1:0]   valid_q, valid_d;
   logic [27:0]            line_addr_q, line_addr_d;
   logic                   kill_q, kill_d;
   logic                   hit_vld_q, hit_vld_d;
   logic [127:0]           resp_data_q, resp_data_d;
   logic [127:0]           dout_hold_q, dout_hold_d;
   logic                   mem_err_q, mem_err_d;
   logic [31:0]            wait_cnt_q, wait_cnt_d;
   logic                   fill_we;

   // Tag and data arrays carry no reset; the valid bits gate every use.
   logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
   logic [127:0]           data_mem [NUM_LINES];

   logic [INDEX_BITS-1:0]  req_idx;
   logic [TAG_W-1:0]       req_tag;
   logic [INDEX_BITS-1:0]  fill_idx;
   logic [TAG_W-1:0]       fill_tag;
   logic                   lookup_hit;
   logic                   req_accept;
   logic                   unused_pc_offset;

   assign req_idx          = Pc_in[INDEX_BITS+3:4];
   assign req_tag          = Pc_in[31:INDEX_BITS+4];
   assign fill_idx         = line_addr_q[INDEX_BITS-1:0];
   assign fill_tag         = line_addr_q[27:INDEX_BITS];
   assign unused_pc_offset = ^Pc_in[3:0];

   assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   assign req_accept = (state_q == StIdle) && Rd_en && !Abort;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      line_addr_d = line_addr_q;
      kill_d      = kill_q;
      hit_vld_d   = 1'b0;
      resp_data_d = resp_data_q;
      mem_err_d   = mem_err_q;
      wait_cnt_d  = wait_cnt_q;
      fill_we     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req_accept) begin
               if (lookup_hit) begin
                  hit_vld_d   = 1'b1;
                  resp_data_d = data_mem[req_idx];
               end else begin
                  line_addr_d = Pc_in[31:4];
                  state_d     = StMiss;
               end
            end
         end

         StMiss: begin
            if (Abort) begin
               kill_d = 1'b1;
            end
            wait_cnt_d = '0;
            state_d    = StWait;
         end

         StWait: begin
            if (Abort) begin
               kill_d = 1'b1;
            end
            if (Mem_data_valid) begin
               // The fill always lands in the cache, even when killed.
               fill_we           = 1'b1;
               valid_d[fill_idx] = 1'b1;
               resp_data_d       = Mem_data;
               state_d           = StResp;
            end else if (wait_cnt_q == 32'(MEM_TIMEOUT - 1)) begin
               mem_err_d = 1'b1;
               kill_d    = 1'b0;
               state_d   = StIdle;
            end else begin
               wait_cnt_d = wait_cnt_q + 32'd1;
            end
         end

         StResp: begin
            kill_d  = 1'b0;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // Abort suppresses whichever response is on the bus this cycle.
   always_comb begin
      Dout_valid  = !Abort && (hit_vld_q || ((state_q == StResp) && !kill_q));
      Dout        = Dout_valid ? resp_data_q : dout_hold_q;
      dout_hold_d = Dout;
   end

   assign Busy      = (state_q != StIdle);
   assign Mem_rd_en = (state_q == StMiss);
   assign Mem_addr  = {line_addr_q, 4'b0000};
   assign Mem_err   = mem_err_q;

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         valid_q     <= '0;
         line_addr_q <= '0;
         kill_q      <= 1'b0;
         hit_vld_q   <= 1'b0;
         resp_data_q <= '0;
         dout_hold_q <= '0;
         mem_err_q   <= 1'b0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         line_addr_q <= line_addr_d;
         kill_q      <= kill_d;
         hit_vld_q   <= hit_vld_d;
         resp_data_q <= resp_data_d;
         dout_hold_q <= dout_hold_d;
         mem_err_q   <= mem_err_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= Mem_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------------
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (req_accept) begin
         if (lookup_hit) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
         end else begin
            miss_cnt_d = miss_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign Hit_count  = hit_cnt_q;
   assign Miss_count = miss_cnt_q;
`else
   assign Hit_count  = '0;
   assign Miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_ctrl: self-checking bench for icache_ctrl. A transaction-level
// model (resident line address + data per index, response hold value, sticky
// error, hit/miss tallies) predicts every observed output.
// -----------------------------------------------------------------------------
module tb_icache_ctrl;

   localparam int IB = 4;
   localparam int NL = 1 << IB;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   Pc_in;
   logic          Rd_en;
   logic          Abort;
   logic [127:0]  Dout;
   logic          Dout_valid;
   logic          Busy;
   logic [31:0]   Mem_addr;
   logic          Mem_rd_en;
   logic [127:0]  Mem_data;
   logic          Mem_data_valid;
   logic          Mem_err;
   logic [31:0]   Hit_count;
   logic [31:0]   Miss_count;

   icache_ctrl #(
      .INDEX_BITS  (IB),
      .MEM_TIMEOUT (TO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .Pc_in          (Pc_in),
      .Rd_en          (Rd_en),
      .Abort          (Abort),
      .Dout           (Dout),
      .Dout_valid     (Dout_valid),
      .Busy           (Busy),
      .Mem_addr       (Mem_addr),
      .Mem_rd_en      (Mem_rd_en),
      .Mem_data       (Mem_data),
      .Mem_data_valid (Mem_data_valid),
      .Mem_err        (Mem_err),
      .Hit_count      (Hit_count),
      .Miss_count     (Miss_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model
   bit           m_valid [NL];
   logic [27:0]  m_line  [NL];
   logic [127:0] m_data  [NL];
   logic [31:0]  m_hits;
   logic [31:0]  m_misses;
   logic [127:0] m_hold;
   logic         m_err;

   function automatic logic [31:0] exp_hits();
`ifdef ICACHE_PERF_CNT_EN
      return m_hits;
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [31:0] exp_misses();
`ifdef ICACHE_PERF_CNT_EN
      return m_misses;
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      m_hits   = '0;
      m_misses = '0;
      m_hold   = '0;
      m_err    = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // abort_mode: 0 none, 1 with request, 2 in WAIT (or on hit response),
   // 3 in MISS (or on hit response), 4 in RESP (or on hit response)
   task automatic fetch(input logic [31:0] addr, input int lat, input int abort_mode,
                        input logic [127:0] fill);
      logic [IB-1:0] idx;
      bit            hit;
      logic          exp_v;
      idx = addr[IB+3:4];
      hit = m_valid[idx] && (m_line[idx] == addr[31:4]);
      step();
      Pc_in = addr;
      Rd_en = 1'b1;
      Abort = (abort_mode == 1);
      step();
      Rd_en = 1'b0;
      Abort = 1'b0;
      if (abort_mode == 1) begin
         @(negedge clk);
         n_checks++; if (Dout_valid !== 1'b0 || Mem_rd_en !== 1'b0 || Busy !== 1'b0)
            $display("FAIL drop_req: valid=%b rd_en=%b busy=%b want 0 0 0",
                     Dout_valid, Mem_rd_en, Busy); else n_pass++;
      end else if (hit) begin
         m_hits++;
         Abort = (abort_mode >= 2);
         exp_v = (abort_mode < 2);
         @(negedge clk);
         n_checks++; if (Dout_valid !== exp_v)
            $display("FAIL hit_valid %h: got %b want %b", addr, Dout_valid, exp_v);
            else n_pass++;
         if (exp_v) m_hold = m_data[idx];
         n_checks++; if (Dout !== m_hold)
            $display("FAIL hit_data %h: got %h want %h", addr, Dout, m_hold); else n_pass++;
         n_checks++; if (Mem_rd_en !== 1'b0 || Busy !== 1'b0)
            $display("FAIL hit_idle %h: rd_en=%b busy=%b want 0 0", addr, Mem_rd_en, Busy);
            else n_pass++;
         step();
         Abort = 1'b0;
         @(negedge clk);
         n_checks++; if (Dout_valid !== 1'b0 || Dout !== m_hold)
            $display("FAIL hit_after %h: valid=%b dout=%h want 0 %h", addr, Dout_valid, Dout,
                     m_hold); else n_pass++;
      end else begin
         m_misses++;
         Abort = (abort_mode == 3);
         @(negedge clk);
         n_checks++; if (Mem_rd_en !== 1'b1 || Mem_addr !== {addr[31:4], 4'b0})
            $display("FAIL miss_req %h: rd_en=%b addr=%h want 1 %h", addr, Mem_rd_en,
                     Mem_addr, {addr[31:4], 4'b0}); else n_pass++;
         for (int k = 1; k <= lat; k++) begin
            step();
            Abort          = (abort_mode == 2) && (k == 1);
            Mem_data_valid = (k == lat);
            Mem_data       = fill;
            @(negedge clk);
            if (k == 1) begin
               n_checks++; if (Mem_rd_en !== 1'b0 || Busy !== 1'b1)
                  $display("FAIL wait_state %h: rd_en=%b busy=%b want 0 1", addr, Mem_rd_en,
                           Busy); else n_pass++;
            end
         end
         step();
         Mem_data_valid = 1'b0;
         Abort          = (abort_mode == 4);
         exp_v          = (abort_mode < 2);
         @(negedge clk);
         n_checks++; if (Dout_valid !== exp_v)
            $display("FAIL resp_valid %h: got %b want %b", addr, Dout_valid, exp_v);
            else n_pass++;
         if (exp_v) m_hold = fill;
         n_checks++; if (Dout !== m_hold)
            $display("FAIL resp_data %h: got %h want %h", addr, Dout, m_hold); else n_pass++;
         m_valid[idx] = 1'b1;
         m_line[idx]  = addr[31:4];
         m_data[idx]  = fill;
         step();
         Abort = 1'b0;
         @(negedge clk);
         n_checks++; if (Busy !== 1'b0 || Dout_valid !== 1'b0)
            $display("FAIL resp_after %h: busy=%b valid=%b want 0 0", addr, Busy, Dout_valid);
            else n_pass++;
      end
      n_checks++; if (Hit_count !== exp_hits() || Miss_count !== exp_misses())
         $display("FAIL counters %h: hit=%0d miss=%0d want %0d %0d", addr, Hit_count,
                  Miss_count, exp_hits(), exp_misses()); else n_pass++;
      n_checks++; if (Mem_err !== m_err)
         $display("FAIL mem_err %h: got %b want %b", addr, Mem_err, m_err); else n_pass++;
   endtask

   task automatic test_reset();
      reset          = 1'b0;
      Pc_in          = 32'h0000_0040;
      Rd_en          = 1'b1;
      Abort          = 1'b0;
      Mem_data       = '1;
      Mem_data_valid = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      n_checks++; if (Dout !== '0 || Dout_valid !== 1'b0 || Busy !== 1'b0)
         $display("FAIL reset_out: dout=%h valid=%b busy=%b want 0 0 0", Dout, Dout_valid,
                  Busy); else n_pass++;
      n_checks++; if (Mem_rd_en !== 1'b0 || Mem_addr !== '0 || Mem_err !== 1'b0)
         $display("FAIL reset_mem: rd_en=%b addr=%h err=%b want 0 0 0", Mem_rd_en, Mem_addr,
                  Mem_err); else n_pass++;
      n_checks++; if (Hit_count !== '0 || Miss_count !== '0)
         $display("FAIL reset_cnt: hit=%0d miss=%0d want 0 0", Hit_count, Miss_count);
         else n_pass++;
      Rd_en          = 1'b0;
      Mem_data_valid = 1'b0;
      reset          = 1'b1;
   endtask

   task automatic test_directed();
      logic [127:0] d1;
      d1 = 128'h11111111_22222222_33333333_44444444;
      fetch(32'h0000_0040, 3, 0, d1);
      fetch(32'h0000_0048, 1, 0, '0);
      fetch(32'h0000_0140, 2, 0, 128'hAAAA_0140);
      fetch(32'h0000_0040, 2, 0, d1);
      fetch(32'h0000_0240, 3, 2, 128'hBBBB_0240);
      fetch(32'h0000_0244, 1, 0, '0);
      fetch(32'h0000_0350, 2, 3, 128'hCCCC_0350);
      fetch(32'h0000_0460, 2, 4, 128'hDDDD_0460);
      fetch(32'h0000_0460, 1, 2, '0);
      fetch(32'h0000_0460, 1, 1, '0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a [6];
      logic [IB-1:0] idx;
      for (int i = 0; i < 4; i++)
         fetch(32'h0000_1000 + 32'(i * 16), 1, 0, {4{32'(i) ^ 32'h5A5A_0000}});
      a[0] = 32'h0000_1000; a[1] = 32'h0000_1014; a[2] = 32'h0000_1028;
      a[3] = 32'h0000_103C; a[4] = 32'h0000_1004; a[5] = 32'h0000_1020;
      step();
      Pc_in = a[0];
      Rd_en = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (i < 6) Pc_in = a[i];
         else Rd_en = 1'b0;
         idx = a[i-1][IB+3:4];
         m_hits++;
         m_hold = m_data[idx];
         @(negedge clk);
         n_checks++; if (Dout_valid !== 1'b1 || Dout !== m_hold)
            $display("FAIL b2b_%0d: valid=%b dout=%h want 1 %h", i, Dout_valid, Dout, m_hold);
            else n_pass++;
      end
      step();
      @(negedge clk);
      n_checks++; if (Dout_valid !== 1'b0 || Hit_count !== exp_hits())
         $display("FAIL b2b_end: valid=%b hit=%0d want 0 %0d", Dout_valid, Hit_count,
                  exp_hits()); else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0]  addr;
      logic [127:0] fill;
      int           mode;
      for (int it = 0; it < 60; it++) begin
         addr = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 4) |
                32'($urandom_range(0, 15));
         fill = {$urandom, $urandom, $urandom, $urandom};
         mode = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
         fetch(addr, int'($urandom_range(1, 5)), mode, fill);
         if ($urandom_range(0, 4) == 0) begin
            // Stray refill data while idle must not touch anything.
            step();
            Mem_data_valid = 1'b1;
            Mem_data       = {$urandom, $urandom, $urandom, $urandom};
            step();
            Mem_data_valid = 1'b0;
            @(negedge clk);
            n_checks++; if (Dout_valid !== 1'b0 || Busy !== 1'b0 || Dout !== m_hold)
               $display("FAIL stray_mdv: valid=%b busy=%b dout=%h want 0 0 %h", Dout_valid,
                        Busy, Dout, m_hold); else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_refill();
      fetch(32'h0000_3010, 2, 0, 128'h3010_3010);
      step();
      Pc_in = 32'h0000_3110;
      Rd_en = 1'b1;
      step();
      Rd_en = 1'b0;
      step();
      step();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      n_checks++; if (Busy !== 1'b0 || Dout_valid !== 1'b0 || Mem_addr !== '0 ||
                      Hit_count !== '0 || Miss_count !== '0)
         $display("FAIL mid_reset: busy=%b valid=%b addr=%h hit=%0d miss=%0d want all 0",
                  Busy, Dout_valid, Mem_addr, Hit_count, Miss_count); else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      step();
      Mem_data_valid = 1'b1;
      Mem_data       = 128'hDEAD;
      step();
      Mem_data_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (Dout_valid !== 1'b0 || Busy !== 1'b0 || Dout !== '0)
         $display("FAIL post_reset_mdv: valid=%b busy=%b dout=%h want 0 0 0", Dout_valid,
                  Busy, Dout); else n_pass++;
      fetch(32'h0000_3010, 2, 0, 128'h3010_0002);
   endtask

   task automatic test_timeout();
      step();
      Pc_in = 32'h0000_5000;
      Rd_en = 1'b1;
      step();
      Rd_en = 1'b0;
      m_misses++;
      @(negedge clk);
      n_checks++; if (Mem_rd_en !== 1'b1 || Mem_addr !== 32'h0000_5000)
         $display("FAIL to_req: rd_en=%b addr=%h want 1 00005000", Mem_rd_en, Mem_addr);
         else n_pass++;
      for (int k = 1; k <= TO; k++) begin
         step();
         @(negedge clk);
         if (k == TO) begin
            n_checks++; if (Busy !== 1'b1 || Mem_err !== 1'b0)
               $display("FAIL to_last_wait: busy=%b err=%b want 1 0", Busy, Mem_err);
               else n_pass++;
         end
      end
      step();
      m_err = 1'b1;
      @(negedge clk);
      n_checks++; if (Busy !== 1'b0 || Mem_err !== 1'b1 || Dout_valid !== 1'b0)
         $display("FAIL to_flag: busy=%b err=%b valid=%b want 0 1 0", Busy, Mem_err,
                  Dout_valid); else n_pass++;
      step();
      Mem_data_valid = 1'b1;
      Mem_data       = 128'h5000;
      step();
      Mem_data_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (Dout_valid !== 1'b0 || Busy !== 1'b0)
         $display("FAIL to_late_mdv: valid=%b busy=%b want 0 0", Dout_valid, Busy);
         else n_pass++;
      fetch(32'h0000_5000, 2, 0, 128'h5000_0001);
      fetch(32'h0000_5004, 1, 0, '0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      model_reset();
      n_checks++; if (Mem_err !== 1'b0)
         $display("FAIL to_clear: err=%b want 0", Mem_err); else n_pass++;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_mid_refill();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter INDEX_BITS, default 4, line-index width; cache holds 2^INDEX_BITS lines of 128 bits.
REQ-002 Parameter MEM_TIMEOUT, default 64, cycles WAIT tolerates before flagging Mem_err.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Pc_in  input  32  fetch address from instruction fetch queue.
REQ-006 Rd_en  input  1  fetch request, held by requester until serviced.
REQ-007 Abort  input  1  branch/jump redirect; kills in-flight response.
REQ-008 Dout  output  128  fetched line, word 0 in [127:96].
REQ-009 Dout_valid  output  1  one-cycle pulse; Dout valid this cycle.
REQ-010 Busy  output  1  high in any state other than IDLE.
REQ-011 Mem_addr  output  32  line-aligned refill address.
REQ-012 Mem_rd_en  output  1  one-cycle refill request pulse.
REQ-013 Mem_data  input  128  refill line.
REQ-014 Mem_data_valid  input  1  Mem_data valid this cycle.
REQ-015 Mem_err  output  1  sticky timeout flag, cleared only by reset.
REQ-016 Hit_count, Miss_count  output  32 each  performance counters.

Function
REQ-017 Address split: offset Pc_in[3:0] ignored; index Pc_in[INDEX_BITS+3:4]; tag Pc_in[31:INDEX_BITS+4].
REQ-018 Storage: per line one valid bit, tag, 128-bit data; direct-mapped.
REQ-019 FSM states IDLE, MISS, WAIT, RESP; only IDLE samples Rd_en, requests in other states ignored.
REQ-020 IDLE, Rd_en=1, Abort=0, hit: Dout=line data and Dout_valid=1 on next cycle (1-cycle latency); stay IDLE; back-to-back hits every cycle.
REQ-021 IDLE, Rd_en=1, Abort=0, miss: latch Pc_in line address, go to MISS.
REQ-022 MISS: Mem_rd_en=1, Mem_addr={latched[31:4],4'b0} for exactly one cycle; go to WAIT.
REQ-023 WAIT: on Mem_data_valid write data, tag, set valid for latched index; go to RESP.
REQ-024 RESP: Dout=filled line, Dout_valid=1 for one cycle unless killed; go to IDLE.
REQ-025 Abort in IDLE same cycle as Rd_en: request dropped, no lookup, no counter change.
REQ-026 Abort in IDLE the cycle a hit response is driven: Dout_valid forced 0.
REQ-027 Abort in MISS or WAIT: set kill flag; refill still completes and is written to cache; RESP drives Dout_valid=0; kill flag clears in RESP.
REQ-028 Abort in RESP: Dout_valid forced 0.
REQ-029 Mem_data_valid outside WAIT ignored.
REQ-030 WAIT lasting MEM_TIMEOUT cycles: set Mem_err, return to IDLE, no fill, no Dout_valid.
REQ-031 Dout holds last driven value when Dout_valid=0.
REQ-032 Busy and Mem_rd_en are decoded from registered state only.

Reset
REQ-033 reset=0 asynchronously: state IDLE, all valid bits 0, kill flag 0, Dout=0, Dout_valid=0, Mem_rd_en=0, Mem_addr=0, Mem_err=0, counters 0.
REQ-034 Reset mid-refill abandons it; a later Mem_data_valid in IDLE is ignored.
REQ-035 Data and tag arrays need not be cleared by reset.

Configuration
REQ-036 Macro ICACHE_PERF_CNT_EN defined: Hit_count +1 per accepted hit, Miss_count +1 per accepted miss, both wrap at 2^32.
REQ-037 Macro undefined: counter logic absent, Hit_count and Miss_count tied to 0; ports remain.

Verification
REQ-038 Cold fetch 0x0000_0040 after reset -> Mem_rd_en pulse, Mem_addr=0x0000_0040; Mem_data_valid 3 cycles later with 0x1111..._4444 -> Dout_valid one cycle after fill with that data.
REQ-039 Then Rd_en with 0x0000_0048 -> no Mem_rd_en, Dout_valid next cycle, same data; Hit_count=1, Miss_count=1 (macro on).
REQ-040 Fetch 0x0000_0140 (same index, new tag) -> miss, Mem_addr=0x0000_0140; refetch 0x0000_0040 -> miss again.
REQ-041 Abort during WAIT -> fill written, Dout_valid stays 0; refetch same address -> 1-cycle hit.
REQ-042 reset low during WAIT, then Mem_data_valid -> state IDLE, Dout_valid 0, refetch misses.
REQ-043 No Mem_data_valid for MEM_TIMEOUT cycles -> Mem_err=1, Busy=0, Mem_err persists until reset.
